ldlt_stream: RTL
================

LDLT_STREAM -- requirements
Module: ldlt_stream

Interface
REQ-001 SHALL have parameter DATA_LEN, default 32: width of every matrix element, signed two's complement.
REQ-002 SHALL have parameter FRACTION, default 16: fractional bits (fixed-point Q(DATA_LEN-FRACTION).FRACTION).
REQ-003 SHALL have parameter N, default 8, legal range 2..64: matrix dimension; elements per job M = N(N+1)/2.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_start  input  1  job start pulse; honoured only in IDLE.
REQ-007 SHALL have port i_valid  input  1  input element valid.
REQ-008 SHALL have port o_in_ready  output  1  block accepts input element.
REQ-009 SHALL have port i_data  input  DATA_LEN  input element (lower-triangle A, column-major: j=0..N-1, i=j..N-1).
REQ-010 SHALL have port o_valid  output  1  output element valid.
REQ-011 SHALL have port i_ready  input  1  downstream accepts output element.
REQ-012 SHALL have port o_data  output  DATA_LEN  output element, same order as input; diagonal slot carries D_jj, off-diagonal carries L_ij.
REQ-013 SHALL have port o_last  output  1  marks M-th output element.
REQ-014 SHALL have port o_busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port o_err  output  1  sticky per job: a zero pivot D_jj==0 occurred.
REQ-016 SHALL have port o_ovf  output  1  sticky per job: a division result saturated.

Function
REQ-017 SHALL implement states IDLE, LOAD, DIAG, LTRI, OUT; IDLE->LOAD on i_start; LOAD->DIAG after M-th accepted element; DIAG(j)->LTRI(j) if j<N-1, else ->OUT; LTRI(j) after row N-1 ->DIAG(j+1); OUT->IDLE after M-th handshake.
REQ-018 SHALL assert o_in_ready exactly in LOAD; element accepted when i_valid && o_in_ready; i_valid outside LOAD ignored.
REQ-019 SHALL clear o_err and o_ovf on the cycle i_start is accepted.
REQ-020 SHALL store the job in internal registers of M words; no external memory.
REQ-021 SHALL compute D_jj = A_jj - sum_{k<j} L_jk*L_jk*D_kk and L_ij = (A_ij - sum_{k<j} L_ik*L_jk*D_kk)/D_jj, overwriting A in place.
REQ-022 SHALL spend exactly j+1 cycles per element of column j: k=0..j-1 one MAC term per cycle, k=j finalise and write.
REQ-023 SHALL accumulate each triple product at full precision in a 3*DATA_LEN signed accumulator, cleared at k=j.
REQ-024 SHALL scale the accumulator by arithmetic shift of 2*FRACTION rounding toward zero (add 2^(2*FRACTION)-1 when negative) before subtraction.
REQ-025 SHALL compute quotient as (numerator << FRACTION)/D_jj truncating toward zero, saturated to the signed DATA_LEN range; saturation sets o_ovf.
REQ-026 SHALL, when D_jj==0, write 0 to every L_ij of column j, set o_err, and continue.
REQ-027 SHALL assert o_valid on the first OUT cycle and hold o_data/o_last stable while o_valid && !i_ready.
REQ-028 SHALL advance output index only on o_valid && i_ready; o_last high only with M-th element; o_valid low the cycle after its handshake (state IDLE).
REQ-029 SHALL ignore i_start while o_busy; a new job may start the cycle after return to IDLE.

Reset
REQ-030 SHALL on rst_n low, at any time including mid-job, force IDLE and zero o_in_ready, o_valid, o_data, o_last, o_busy, o_err, o_ovf, all counters and accumulator; stored data need not be cleared.

Verification
REQ-031 N=2, inputs 0x40000,0x20000,0x50000, i_ready=1 -> outputs 0x40000,0x08000,0x40000, o_last on third, o_err=0, o_ovf=0.
REQ-032 N=4, identity matrix input -> 10 outputs, 0x10000 at diagonal slots (positions 0,4,7,9), 0 elsewhere.
REQ-033 N=2, inputs 0,0x10000,0x30000 -> o_err=1, outputs 0,0,0x30000.
REQ-034 N=2, inputs 0x1,0x640000,0x10000 -> second output 0x7FFFFFFF, o_ovf=1.
REQ-035 REQ-031 with i_ready low 5 cycles while first output valid -> o_data held 0x40000, no element lost or duplicated.
REQ-036 rst_n pulsed low after 2 of 3 accepted inputs -> all outputs 0 immediately; subsequent clean REQ-031 job yields identical results.

Source files
------------

// File: rtl/ldlt_stream.sv
// rtl/ldlt_stream.sv - streaming in-place fixed-point LDL^T factorisation of an N x N symmetric matrix
// Lower triangle held column-major in M=N(N+1)/2 registers; one MAC term per cycle.
module ldlt_stream #(
  parameter int DATA_LEN = 32,
  parameter int FRACTION = 16,
  parameter int N        = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic                i_valid,
  output logic                o_in_ready,
  input  logic [DATA_LEN-1:0] i_data,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [DATA_LEN-1:0] o_data,
  output logic                o_last,
  output logic                o_busy,
  output logic                o_err,
  output logic                o_ovf
);
  localparam int M  = N * (N + 1) / 2;
  localparam int JW = $clog2(N);
  localparam int IW = $clog2(M);
  localparam int AW = 3 * DATA_LEN;
  localparam int QW = AW + FRACTION;
  localparam logic [JW-1:0] LASTJ = JW'(N - 1);
  localparam logic [IW-1:0] LASTC = IW'(M - 1);
  localparam logic [AW-1:0] RND = {{(AW - 2 * FRACTION){1'b0}}, {(2 * FRACTION){1'b1}}};
  localparam logic signed [QW-1:0] QMAX = QW'({1'b0, {(DATA_LEN - 1){1'b1}}});
  localparam logic signed [QW-1:0] QMIN = ~QMAX;

  typedef enum logic [2:0] {IDLE, LOAD, DIAG, LTRI, OUT} state_t;
  state_t state, state_nx;

  logic [JW-1:0] ci, cj, ck;
  logic [IW-1:0] cnt;
  logic signed [AW-1:0] acc;
  logic [DATA_LEN-1:0] mem [M];

  function automatic logic [IW-1:0] tri_idx(input logic [JW-1:0] i, input logic [JW-1:0] j);
    int ii = int'(i);
    int jj = int'(j);
    return IW'(jj * N - (jj * (jj - 1)) / 2 + ii - jj);
  endfunction

  logic accept, handshake, fin;
  assign accept    = (state == LOAD) && i_valid;
  assign handshake = (state == OUT) && i_ready;
  assign fin       = ((state == DIAG) || (state == LTRI)) && (ck == cj);

  logic signed [DATA_LEN-1:0] l_ik, l_jk, d_kk, a_ij, d_jj;
  assign l_ik = mem[tri_idx(ci, ck)];
  assign l_jk = mem[tri_idx(cj, ck)];
  assign d_kk = mem[tri_idx(ck, ck)];
  assign a_ij = mem[tri_idx(ci, cj)];
  assign d_jj = mem[tri_idx(cj, cj)];

  logic signed [2*DATA_LEN-1:0] p2;
  logic signed [AW-1:0] p3, rnd_acc, scaled, num;
  assign p2 = (2*DATA_LEN)'(l_ik) * (2*DATA_LEN)'(l_jk);
  assign p3 = AW'(p2) * AW'(d_kk);
  // Round toward zero: bias negative sums before the arithmetic shift.
  assign rnd_acc = (acc < 0) ? acc + $signed(RND) : acc;
  assign scaled  = rnd_acc >>> (2 * FRACTION);
  assign num     = AW'(a_ij) - scaled;

  logic signed [QW-1:0] nsh, dvs, quot;
  logic sat_hi, sat_lo, zero_piv;
  logic [DATA_LEN-1:0] d_new, l_new, wdata;
  logic [IW-1:0] waddr;
  logic we;
  assign zero_piv = (d_jj == '0);
  assign nsh    = QW'(num) <<< FRACTION;
  assign dvs    = zero_piv ? QW'(1) : QW'(d_jj);
  assign quot   = nsh / dvs;
  assign sat_hi = quot > QMAX;
  assign sat_lo = quot < QMIN;
  assign d_new  = num[DATA_LEN-1:0];
  assign l_new  = zero_piv ? '0 : sat_hi ? QMAX[DATA_LEN-1:0] :
                  sat_lo ? QMIN[DATA_LEN-1:0] : quot[DATA_LEN-1:0];
  assign we     = accept || fin;
  assign waddr  = (state == LOAD) ? cnt : tri_idx(ci, cj);
  assign wdata  = (state == LOAD) ? i_data : (state == DIAG) ? d_new : l_new;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (i_start) state_nx = LOAD;
      LOAD: if (accept && cnt == LASTC) state_nx = DIAG;
      DIAG: if (fin) state_nx = (cj == LASTJ) ? OUT : LTRI;
      LTRI: if (fin && ci == LASTJ) state_nx = DIAG;
      OUT:  if (handshake && cnt == LASTC) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    o_in_ready = (state == LOAD);
    o_valid    = (state == OUT);
    o_busy     = (state != IDLE);
    o_last     = (state == OUT) && (cnt == LASTC);
    o_data     = (state == OUT) ? mem[cnt] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ci <= '0; cj <= '0; ck <= '0; cnt <= '0; acc <= '0;
      o_err <= 1'b0; o_ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_start) begin
          ci <= '0; cj <= '0; ck <= '0; cnt <= '0; acc <= '0;
          o_err <= 1'b0; o_ovf <= 1'b0;
        end
        LOAD: if (accept) cnt <= (cnt == LASTC) ? '0 : cnt + 1'b1;
        DIAG, LTRI: begin
          if (fin) begin
            acc <= '0;
            ck  <= '0;
            if (state == DIAG) begin
              if (d_new == '0) o_err <= 1'b1;
              if (cj != LASTJ) ci <= cj + 1'b1;
            end else begin
              if (zero_piv) o_err <= 1'b1;
              else if (sat_hi || sat_lo) o_ovf <= 1'b1;
              if (ci == LASTJ) begin
                cj <= cj + 1'b1;
                ci <= cj + 1'b1;
              end else begin
                ci <= ci + 1'b1;
              end
            end
          end else begin
            acc <= acc + p3;
            ck  <= ck + 1'b1;
          end
        end
        OUT: if (handshake) cnt <= (cnt == LASTC) ? '0 : cnt + 1'b1;
        default: ;
      endcase
    end
  end
endmodule
